seq_multiplier: RTL

Sequential 3-bit x 3-bit unsigned shift-and-add multiplier producing a 6-bit product. It sits directly upstream of the 3-bit carry-lookahead adder and drives it: one adder instance is fed with the running partial sum and the multiplicand each iteration. It consumes the adder's sum and carry-out. A start/busy/done handshake lets a controller launch one multiplication at a time.

---
 rtl/seq_multiplier.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential 3x3 unsigned shift-and-add multiplier with a 6-bit product.
// State advances on the falling clock edge; the partial sum goes through a 3-bit carry-lookahead adder.
module seq_multiplier (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic       busy,
    output logic       done,
    output logic [5:0] product
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  mcand_q, mcand_d;
    logic [5:0]  acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [5:0]  product_q, product_d;

    logic [2:0]  addend;
    logic [2:0]  add_g, add_p;
    logic [3:0]  add_c;
    logic [2:0]  add_sum;
    logic [5:0]  acc_shift;
    logic        accept;
    logic        last_iter;

    assign addend = acc_q[0] ? mcand_q : 3'b000;

    // 3-bit carry-lookahead adder: partial sum + gated multiplicand, carry-in tied low
    always_comb begin
        add_g    = acc_q[5:3] & addend;
        add_p    = acc_q[5:3] ^ addend;
        add_c[0] = 1'b0;
        add_c[1] = add_g[0] | (add_p[0] & add_c[0]);
        add_c[2] = add_g[1] | (add_p[1] & add_g[0]) | (add_p[1] & add_p[0] & add_c[0]);
        add_c[3] = add_g[2] | (add_p[2] & add_g[1]) | (add_p[2] & add_p[1] & add_g[0])
                 | (add_p[2] & add_p[1] & add_p[0] & add_c[0]);
        add_sum  = add_p ^ add_c[2:0];
    end

    // Carry lands in bit 5 as the whole accumulator shifts right by one
    assign acc_shift = {add_c[3], add_sum, acc_q[2:1]};
    assign last_iter = (cnt_q == 2'd2);
    assign accept    = start && (state_q != S_RUN);

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            mcand_d = x;
            acc_d   = {3'b000, y};
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            acc_d = acc_shift;
            cnt_d = cnt_q + 2'd1;
            if (last_iter) begin
                product_d = acc_shift;
            end
        end
    end

    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        product = product_q;
    end

endmodule
